// File: rtl/ccff_pkg.sv
// Shared definitions for the configuration-chain loader.
//  - state_e        : loader FSM states
//  - WORD_W_DEF     : default bitstream word width
//  - CHAIN_LEN_DEF  : default number of config FFs in the fabric chain
package ccff_pkg;

    localparam int unsigned WORD_W_DEF    = 8;
    localparam int unsigned CHAIN_LEN_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ccff_word_serializer.sv
// Word buffer and bit serializer feeding the config chain head.
// Ports:
//  clk, rst_n    clock, async active-low reset
//  en            loader is in LOAD; shifting and handshakes allowed
//  arm           loader will be in LOAD next cycle; qualifies s_ready
//  discard       last chain bit is being issued; drop whatever is left
//  s_valid/s_ready/s_data  bitstream word stream (bit 0 first)
//  ccff_head     registered serial data to chain head (holds when idle)
//  ccff_shift    registered chain shift enable
//  issue_c       a bit is being issued on this edge
//  head_nxt_c    value ccff_head takes on this edge
module ccff_word_serializer #(
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              arm,
    input  logic              discard,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              ccff_shift,
    output logic              issue_c,
    output logic              head_nxt_c
);

    localparam int unsigned LEFT_W = $clog2(WORD_W + 1);

    // left_q counts buffered bits not yet placed on the head; the bit
    // currently on ccff_head is already out of the buffer.
    logic [WORD_W-1:0] buf_q;
    logic [WORD_W-1:0] buf_adv;
    logic [WORD_W-1:0] buf_d;
    logic [LEFT_W-1:0] left_q;
    logic [LEFT_W-1:0] left_adv;
    logic [LEFT_W-1:0] left_d;
    logic              ready_d;

    // Issue the next bit: from the buffer if it holds any, otherwise bit 0
    // of a word accepted on this edge (gives one-cycle handshake latency).
    always_comb begin
        issue_c    = 1'b0;
        head_nxt_c = ccff_head;
        buf_adv    = buf_q;
        left_adv   = left_q;
        if (en) begin
            if (left_q != '0) begin
                issue_c    = 1'b1;
                head_nxt_c = buf_q[0];
                buf_adv    = buf_q >> 1;
                left_adv   = left_q - LEFT_W'(1);
            end else if (s_valid && s_ready) begin
                issue_c    = 1'b1;
                head_nxt_c = s_data[0];
                buf_adv    = s_data >> 1;
                left_adv   = LEFT_W'(WORD_W - 1);
            end
        end
    end

    // Kept outside the block above so discard (derived from issue_c) forms no loop.
    assign buf_d   = discard ? '0 : buf_adv;
    assign left_d  = discard ? '0 : left_adv;
    assign ready_d = arm && !discard && (left_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            left_q     <= '0;
            s_ready    <= 1'b0;
            ccff_head  <= 1'b0;
            ccff_shift <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            left_q     <= left_d;
            s_ready    <= ready_d;
            ccff_head  <= head_nxt_c;
            ccff_shift <= issue_c;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Writer side of the fabric configuration chain: serialises bitstream words
// LSB-first onto ccff_head, stops after exactly CHAIN_LEN bits, then checks
// continuity by comparing ccff_tail with the first bit shifted.
// Ports:
//  prog_clk, pReset_n       clock, async active-low reset
//  start                    begin a load (honoured in IDLE/DONE only)
//  s_valid/s_ready/s_data   bitstream word stream
//  ccff_head/ccff_shift     chain head data and shift enable
//  ccff_tail                chain tail output
//  busy, done, error        status (error valid when done)
//  bits_loaded              bits shifted in the current load
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              ccff_shift,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bits_loaded
);

    localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);

    state_e            state_q;
    state_e            state_d;
    logic              busy_d;
    logic              done_d;
    logic              err_d;
    logic [CNT_W-1:0]  bl_d;
    logic              sentinel_q;
    logic              sentinel_d;
    logic              issue_c;
    logic              head_nxt_c;
    logic              discard_c;
    logic              ser_en;
    logic              ser_arm;

    assign ser_en  = (state_q == LOAD);
    assign ser_arm = (state_d == LOAD);

    // The bit issued when bits_loaded is CHAIN_LEN-1 is the last one.
    assign discard_c = (state_q == LOAD) && issue_c && (bits_loaded == LEN_M1);

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .clk        (prog_clk),
        .rst_n      (pReset_n),
        .en         (ser_en),
        .arm        (ser_arm),
        .discard    (discard_c),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .issue_c    (issue_c),
        .head_nxt_c (head_nxt_c)
    );

    // Next state and status. LOAD persists through the cycle showing the last
    // bit so CHECK samples the tail after that bit has been captured.
    always_comb begin
        state_d = state_q;
        err_d   = error;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (bits_loaded == LEN) state_d = CHECK;
            end
            CHECK: begin
                state_d = DONE;
                err_d   = (ccff_tail != sentinel_q);
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    // Bit counter (saturating at CHAIN_LEN) and sentinel capture.
    always_comb begin
        bl_d       = bits_loaded;
        sentinel_d = sentinel_q;
        if ((state_q == DONE) && start) begin
            bl_d = '0;
        end else if ((state_q == LOAD) && issue_c && (bits_loaded != LEN)) begin
            bl_d = bits_loaded + CNT_W'(1);
            if (bits_loaded == '0) sentinel_d = head_nxt_c;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            bits_loaded <= '0;
            sentinel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= err_d;
            bits_loaded <= bl_d;
            sentinel_q  <= sentinel_d;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 12-bit chains), each
// with a behavioural chain model that shifts on ccff_shift.
module tb_ccff_chain_loader;

    localparam int unsigned W  = 8;
    localparam int unsigned L0 = 16;
    localparam int unsigned L1 = 12;

    logic prog_clk = 1'b0;
    logic pReset_n;
    logic start_v [2];
    logic valid_v [2];
    logic [W-1:0] data_v [2];
    logic stuck [2];

    logic rdy0, head0, shift0, tail0, busy0, done0, err0;
    logic [4:0] bl0;
    logic rdy1, head1, shift1, tail1, busy1, done1, err1;
    logic [3:0] bl1;

    logic [L0-1:0] chain0 = '0;
    logic [L1-1:0] chain1 = '0;
    int nsh0 = 0, nsh1 = 0, viol0 = 0, viol1 = 0, run0 = 0, maxrun0 = 0;
    logic ph0 = 1'b0, ph1 = 1'b0;

    int npass = 0, nfail = 0, ntot = 0;
    logic [W-1:0] wl [4];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L0)) u_dut0 (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_v[0]),
        .s_valid(valid_v[0]), .s_ready(rdy0), .s_data(data_v[0]),
        .ccff_head(head0), .ccff_shift(shift0), .ccff_tail(tail0),
        .busy(busy0), .done(done0), .error(err0), .bits_loaded(bl0));

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(L1)) u_dut1 (
        .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start_v[1]),
        .s_valid(valid_v[1]), .s_ready(rdy1), .s_data(data_v[1]),
        .ccff_head(head1), .ccff_shift(shift1), .ccff_tail(tail1),
        .busy(busy1), .done(done1), .error(err1), .bits_loaded(bl1));

    assign tail0 = stuck[0] ? 1'b0 : chain0[L0-1];
    assign tail1 = stuck[1] ? 1'b0 : chain1[L1-1];

    // Chain models plus head-stability and shift-run bookkeeping.
    always @(posedge prog_clk) begin
        if (shift0) begin
            chain0 <= {chain0[L0-2:0], head0};
            nsh0   <= nsh0 + 1;
            run0   <= run0 + 1;
            if (run0 + 1 > maxrun0) maxrun0 <= run0 + 1;
        end else begin
            run0 <= 0;
        end
        if (busy0 && !shift0 && head0 !== ph0) viol0 <= viol0 + 1;
        ph0 <= head0;
    end

    always @(posedge prog_clk) begin
        if (shift1) begin
            chain1 <= {chain1[L1-2:0], head1};
            nsh1   <= nsh1 + 1;
        end
        if (busy1 && !shift1 && head1 !== ph1) viol1 <= viol1 + 1;
        ph1 <= head1;
    end

    function automatic logic f_rdy(input int g);   return (g == 0) ? rdy0  : rdy1;  endfunction
    function automatic logic f_head(input int g);  return (g == 0) ? head0 : head1; endfunction
    function automatic logic f_shift(input int g); return (g == 0) ? shift0 : shift1; endfunction
    function automatic logic f_busy(input int g);  return (g == 0) ? busy0 : busy1; endfunction
    function automatic logic f_done(input int g);  return (g == 0) ? done0 : done1; endfunction
    function automatic logic f_err(input int g);   return (g == 0) ? err0  : err1;  endfunction
    function automatic logic [31:0] f_bl(input int g);    return (g == 0) ? 32'(bl0) : 32'(bl1); endfunction
    function automatic logic [31:0] f_chain(input int g); return (g == 0) ? 32'(chain0) : 32'(chain1); endfunction
    function automatic int f_nsh(input int g);  return (g == 0) ? nsh0 : nsh1; endfunction
    function automatic int f_viol(input int g); return (g == 0) ? viol0 : viol1; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int g);
        start_v[g] = 1'b1;
        @(posedge prog_clk); #1;
        start_v[g] = 1'b0;
    endtask

    // Stream wl[] into instance g; gap = idle cycles with loader ready between
    // words; start_at = word index at which a stray start pulse is issued.
    task automatic run_load(input string tag, input int g, input bit do_start,
                            input int gap, input int start_at);
        int len, nw, k, idle, guard, sh_base, vi_base;
        bit got, rd, pulsed;
        logic [31:0] exp_chain;
        logic exp_err;
        logic [W-1:0] w;
        len = (g == 0) ? int'(L0) : int'(L1);
        nw  = (len + int'(W) - 1) / int'(W);
        // Reference: the chain ends up holding the first len stream bits,
        // first bit deepest; a stuck-0 tail flags an error iff that bit is 1.
        exp_chain = '0;
        for (int i = 0; i < len; i++) begin
            w = wl[i / int'(W)];
            exp_chain = {exp_chain[30:0], w[i % int'(W)]};
        end
        w = wl[0];
        exp_err = stuck[g] && w[0];
        if (do_start) pulse_start(g);
        sh_base = f_nsh(g);
        vi_base = f_viol(g);
        k = 0; idle = 0; guard = 0; pulsed = 1'b0;
        while (k < nw && guard < 400) begin
            valid_v[g] = (idle == 0);
            data_v[g]  = wl[k];
            if (k == start_at && !pulsed) begin
                start_v[g] = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge prog_clk);
            rd  = f_rdy(g);
            got = valid_v[g] && rd;
            @(posedge prog_clk); #1;
            start_v[g] = 1'b0;
            guard++;
            if (got) begin
                k++;
                idle = gap;
            end else if (idle > 0 && rd) begin
                idle--;
            end
        end
        valid_v[g] = 1'b0;
        check({tag, "_handshake_budget"}, 32'(k), 32'(nw));
        guard = 0;
        while (!f_done(g) && guard < 200) begin
            @(posedge prog_clk); #1;
            guard++;
        end
        check({tag, "_done"},   32'(f_done(g)), 32'd1);
        check({tag, "_error"},  32'(f_err(g)),  32'(exp_err));
        check({tag, "_busy"},   32'(f_busy(g)), 32'd0);
        check({tag, "_ready"},  32'(f_rdy(g)),  32'd0);
        check({tag, "_bits"},   f_bl(g), 32'(len));
        check({tag, "_shifts"}, 32'(f_nsh(g) - sh_base), 32'(len));
        check({tag, "_chain"},  f_chain(g), exp_chain);
        check({tag, "_head_stable"}, 32'(f_viol(g) - vi_base), 32'd0);
    endtask

    task automatic check_zero_outputs(input string tag, input int g);
        check({tag, "_s_ready"},     32'(f_rdy(g)),   32'd0);
        check({tag, "_head"},        32'(f_head(g)),  32'd0);
        check({tag, "_shift"},       32'(f_shift(g)), 32'd0);
        check({tag, "_busy"},        32'(f_busy(g)),  32'd0);
        check({tag, "_done"},        32'(f_done(g)),  32'd0);
        check({tag, "_error"},       32'(f_err(g)),   32'd0);
        check({tag, "_bits_loaded"}, f_bl(g),         32'd0);
    endtask

    initial begin
        int base, guard, g, gap, sa;
        pReset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; valid_v[i] = 1'b0; data_v[i] = '0; stuck[i] = 1'b0;
        end
        repeat (3) @(posedge prog_clk);
        #1;
        check_zero_outputs("rst0", 0);
        check_zero_outputs("rst1", 1);
        pReset_n = 1'b1;
        @(posedge prog_clk); #1;

        // 1: back-to-back words on the 16-bit chain
        wl[0] = 8'hA5; wl[1] = 8'h3C;
        run_load("t1", 0, 1'b1, 0, -1);
        check("t1_chain_seq", f_chain(0), 32'h0000_A53C);
        check("t1_no_bubble", 32'(maxrun0), 32'd16);

        // 2: 12-bit chain, second word only partly used
        wl[0] = 8'hFF; wl[1] = 8'h0A;
        run_load("t2", 1, 1'b1, 0, -1);
        check("t2_chain_seq", f_chain(1), 32'h0000_0FF5);

        // 3: starved gaps between words (restart from DONE)
        wl[0] = 8'hA5; wl[1] = 8'h3C;
        run_load("t3", 0, 1'b1, 3, -1);
        check("t3_chain_seq", f_chain(0), 32'h0000_A53C);

        // 4: broken chain (tail stuck at 0) with first bit 1, then healthy chain
        stuck[0] = 1'b1;
        wl[0] = 8'($urandom) | 8'h01; wl[1] = 8'($urandom);
        run_load("t4a", 0, 1'b1, 0, -1);
        check("t4_error_stuck", 32'(err0), 32'd1);
        stuck[0] = 1'b0;
        run_load("t4b", 0, 1'b1, 0, -1);
        check("t4_error_ok", 32'(err0), 32'd0);

        // 5: reset after five shifts, then a fresh load
        wl[0] = 8'($urandom);
        pulse_start(0);
        base = nsh0;
        valid_v[0] = 1'b1; data_v[0] = wl[0];
        guard = 0;
        while (nsh0 - base < 5 && guard < 100) begin
            @(posedge prog_clk); #1;
            guard++;
        end
        check("t5_shifts_before_reset", 32'(nsh0 - base), 32'd5);
        check("t5_busy_before_reset", 32'(busy0), 32'd1);
        pReset_n = 1'b0;
        #1;
        check_zero_outputs("t5_async", 0);
        valid_v[0] = 1'b0;
        @(posedge prog_clk); #1;
        pReset_n = 1'b1;
        @(posedge prog_clk); #1;
        wl[0] = 8'($urandom); wl[1] = 8'($urandom);
        run_load("t5", 0, 1'b1, 0, -1);

        // 6: stray start in LOAD ignored; start in DONE clears status and reloads
        stuck[1] = 1'b1;
        wl[0] = 8'hFF; wl[1] = 8'($urandom);
        run_load("t6a", 1, 1'b1, 0, 1);
        check("t6_error_set", 32'(err1), 32'd1);
        pulse_start(1);
        check("t6_clr_done",  32'(done1), 32'd0);
        check("t6_clr_error", 32'(err1),  32'd0);
        check("t6_clr_bits",  f_bl(1),    32'd0);
        check("t6_busy",      32'(busy1), 32'd1);
        stuck[1] = 1'b0;
        wl[0] = 8'($urandom); wl[1] = 8'($urandom);
        run_load("t6b", 1, 1'b0, 0, -1);

        // Randomised loads against the reference
        for (int n = 0; n < 8; n++) begin
            g   = int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 4));
            sa  = int'($urandom_range(0, 2)) - 1;
            stuck[g] = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) wl[i] = 8'($urandom);
            run_load("rnd", g, 1'b1, gap, sa);
        end
        stuck[0] = 1'b0; stuck[1] = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
